wshb_fb_reader: RTL



---
 rtl/wshb_fb_pkg.sv | 25 ++
 rtl/fb_addr_gen.sv | 69 ++++++
 rtl/wshb_fb_reader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wshb_fb_pkg.sv
// rtl/wshb_fb_pkg.sv - shared types and constants for the framebuffer burst reader
//
// Purpose: FSM state type, default geometry constants and the word-to-byte
// address helper used by wshb_fb_reader and fb_addr_gen.
// Optional feature macro: WSHB_ERR_RETRY_EN (used by the importing modules).
package wshb_fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } fb_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BURST_LEN  = 8;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;

  // Byte address of word 'idx' in a buffer starting at 'base'.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] idx,
                                                 input int          bytes);
    return base + idx * 32'(bytes);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// rtl/fb_addr_gen.sv - word index / byte address generator for the frame reader
//
// Purpose: owns the frame word index, the wishbone byte address derived from
// it, frame wrap-around and the frame_done pulse.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          burst is being launched; remembers the burst start index
//   i_inc            one word acked: advance index and address
//   i_rewind         burst aborted: return to the burst start index
//   o_adr            byte address of the current word
//   o_frame_done     one-cycle pulse, aligned with the push of the last word
// Optional feature macro: WSHB_ERR_RETRY_EN (drives i_rewind from the top).
module fb_addr_gen
  import wshb_fb_pkg::*;
#(
  parameter int          NWORDS    = 384000,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          BYTES     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_inc,
  input  logic        i_rewind,
  output logic [31:0] o_adr,
  output logic        o_frame_done
);

  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [IDX_W-1:0] r_word_idx;
  logic [IDX_W-1:0] r_start_idx;
  logic [31:0]      r_adr;
  logic             r_frame_done;

  logic             w_last;
  logic [IDX_W-1:0] w_next_idx;

  assign w_last     = (r_word_idx == IDX_W'(NWORDS - 1));
  assign w_next_idx = w_last ? '0 : r_word_idx + 1'b1;

  // The address register always mirrors the index so it is ready the
  // moment the FSM raises stb.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word_idx   <= '0;
      r_start_idx  <= '0;
      r_adr        <= BASE_ADDR;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_start) begin
        r_start_idx <= r_word_idx;
      end
      if (i_rewind) begin
        r_word_idx <= r_start_idx;
        r_adr      <= word_byte_addr(BASE_ADDR, 32'(r_start_idx), BYTES);
      end else if (i_inc) begin
        r_word_idx   <= w_next_idx;
        r_adr        <= word_byte_addr(BASE_ADDR, 32'(w_next_idx), BYTES);
        r_frame_done <= w_last;
      end
    end
  end

  assign o_adr        = r_adr;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/wshb_fb_reader.sv
// rtl/wshb_fb_reader.sv - wishbone burst-read master streaming a framebuffer into a pixel FIFO
//
// Purpose: issues BURST_LEN-beat incrementing wishbone reads over the frame,
// pushes each returned word into the pixel FIFO and loops forever while enabled.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_enable                  1 = fetch frames, 0 = stop at next burst boundary
//   o_wshb_cyc/stb/we/sel/adr wishbone master request (we=0, sel all ones)
//   i_wshb_dat_sm/ack/err     wishbone slave response
//   o_fifo_wdata/o_fifo_write pixel FIFO push (registered, one cycle after ack)
//   i_fifo_room               FIFO can take a whole burst
//   o_frame_done              pulse with the push of the last word of a frame
//   o_err_count               saturating error count (WSHB_ERR_RETRY_EN only)
// Optional feature macro: WSHB_ERR_RETRY_EN - err aborts and re-issues the burst.
module wshb_fb_reader
  import wshb_fb_pkg::*;
#(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          BURST_LEN  = DEF_BURST_LEN,
  parameter int          DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  output logic                    o_wshb_cyc,
  output logic                    o_wshb_stb,
  output logic                    o_wshb_we,
  output logic [DATA_WIDTH/8-1:0] o_wshb_sel,
  output logic [31:0]             o_wshb_adr,
  input  logic [DATA_WIDTH-1:0]   i_wshb_dat_sm,
  input  logic                    i_wshb_ack,
  input  logic                    i_wshb_err,
  output logic [DATA_WIDTH-1:0]   o_fifo_wdata,
  output logic                    o_fifo_write,
  input  logic                    i_fifo_room,
  output logic                    o_frame_done
`ifdef WSHB_ERR_RETRY_EN
  ,
  output logic [7:0]              o_err_count
`endif
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  fb_state_t             r_state;
  logic                  r_cyc;
  logic                  r_stb;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_fifo_write;
  logic [DATA_WIDTH-1:0] r_fifo_wdata;

  logic w_err;
  logic w_start;
  logic w_inc;
  logic w_rewind;
  logic w_last_beat;

`ifdef WSHB_ERR_RETRY_EN
  logic [7:0] r_err_count;
  assign w_err = i_wshb_err;
`else
  // Without retry support err is ignored; ack+err counts as a plain ack.
  logic w_err_unused;
  assign w_err_unused = i_wshb_err;
  assign w_err        = 1'b0;
`endif

  assign w_start     = (r_state == IDLE) && i_enable && i_fifo_room;
  assign w_rewind    = (r_state == REQ) && w_err;
  assign w_inc       = (r_state == REQ) && i_wshb_ack && !w_err;
  assign w_last_beat = (r_beat == BEAT_W'(BURST_LEN - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_beat       <= '0;
      r_fifo_write <= 1'b0;
      r_fifo_wdata <= '0;
    end else begin
      r_fifo_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= REQ;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
          end
        end
        REQ: begin
          if (w_rewind) begin
            r_state <= GAP;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_beat  <= '0;
          end else if (i_wshb_ack) begin
            r_fifo_write <= 1'b1;
            r_fifo_wdata <= i_wshb_dat_sm;
            if (w_last_beat) begin
              r_state <= GAP;
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_beat  <= '0;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        // One idle cycle lets the slave return to its idle state.
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef WSHB_ERR_RETRY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_count <= 8'd0;
    end else if (w_rewind && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end
  assign o_err_count = r_err_count;
`endif

  fb_addr_gen #(
    .NWORDS    (HDISP * VDISP),
    .BASE_ADDR (BASE_ADDR),
    .BYTES     (DATA_WIDTH / 8)
  ) u_addr_gen (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (w_start),
    .i_inc        (w_inc),
    .i_rewind     (w_rewind),
    .o_adr        (o_wshb_adr),
    .o_frame_done (o_frame_done)
  );

  assign o_wshb_cyc   = r_cyc;
  assign o_wshb_stb   = r_stb;
  assign o_wshb_we    = 1'b0;
  assign o_wshb_sel   = '1;
  assign o_fifo_write = r_fifo_write;
  assign o_fifo_wdata = r_fifo_wdata;

endmodule
